sad_search_engine: RTL and testbench



---
 rtl/sad_pkg.sv | 27 ++
 rtl/sad_addr_gen.sv | 86 ++++++++
 rtl/sad_search_engine.sv | 131 +++++++++++++
 tb/tb_sad_search_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared widths, FSM state encoding and the pixel absolute-difference helper
// for the full-search SAD engine.
package sad_pkg;

  localparam int PixW   = 8;
  localparam int SadW   = 32;
  localparam int CoordW = 8;

  typedef logic [PixW-1:0]   pixel_t;
  typedef logic [SadW-1:0]   sad_t;
  typedef logic [CoordW-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // The difference is formed in 9-bit signed so 0 - 255 does not wrap.
  function automatic pixel_t abs_diff(input pixel_t a, input pixel_t b);
    logic signed [PixW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[PixW] ? pixel_t'(-d) : pixel_t'(d);
  endfunction

endpackage

// File: rtl/sad_addr_gen.sv
// Nested raster counters (candidate r,c and window offset i,j) and the
// frame/template read addresses they imply.
module sad_addr_gen
  import sad_pkg::*;
#(
  parameter int FrameRows      = 64,
  parameter int FrameCols      = 64,
  parameter int WinRows        = 8,
  parameter int WinCols        = 8,
  parameter int FrameAddrWidth = 12,
  parameter int WinAddrWidth   = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      step_i,
  output logic [FrameAddrWidth-1:0] frame_addr_o,
  output logic [WinAddrWidth-1:0]   win_addr_o,
  output logic [CoordW-1:0]         row_o,
  output logic [CoordW-1:0]         col_o,
  output logic                      first_off_o,
  output logic                      last_off_o,
  output logic                      last_cand_o
);

  localparam coord_t IMax = coord_t'(WinRows - 1);
  localparam coord_t JMax = coord_t'(WinCols - 1);
  localparam coord_t RMax = coord_t'(FrameRows - WinRows);
  localparam coord_t CMax = coord_t'(FrameCols - WinCols);

  coord_t i_q, i_d, j_q, j_d, r_q, r_d, c_q, c_d;
  logic   last_i, last_j, last_r, last_c;

  assign last_i = (i_q == IMax);
  assign last_j = (j_q == JMax);
  assign last_r = (r_q == RMax);
  assign last_c = (c_q == CMax);

  // NOTE: every always_comb output gets its hold value first so no path
  // through the nested ifs can leave it unassigned and infer a latch.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    r_d = r_q;
    c_d = c_q;
    if (step_i) begin
      j_d = last_j ? '0 : j_q + 1'b1;
      if (last_j) begin
        i_d = last_i ? '0 : i_q + 1'b1;
        if (last_i) begin
          c_d = last_c ? '0 : c_q + 1'b1;
          if (last_c) begin
            r_d = last_r ? '0 : r_q + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      r_q <= '0;
      c_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  // Counters wrap to zero after the last issue, so an idle engine drives address 0.
  assign frame_addr_o = FrameAddrWidth'((32'(r_q) + 32'(i_q)) * 32'(FrameCols)
                                        + 32'(c_q) + 32'(j_q));
  assign win_addr_o   = WinAddrWidth'(32'(i_q) * 32'(WinCols) + 32'(j_q));

  assign row_o       = r_q;
  assign col_o       = c_q;
  assign first_off_o = (i_q == '0) && (j_q == '0);
  assign last_off_o  = last_i && last_j;
  assign last_cand_o = last_r && last_c;

endmodule

// File: rtl/sad_search_engine.sv
// Full-search SAD producer: scans every template position over the reference
// frame and emits one (SAD, row, column) triple per position.
module sad_search_engine
  import sad_pkg::*;
#(
  parameter int FrameRows      = 64,
  parameter int FrameCols      = 64,
  parameter int WinRows        = 8,
  parameter int WinCols        = 8,
  parameter int FrameAddrWidth = ($clog2(FrameRows * FrameCols) > 0) ?
                                 $clog2(FrameRows * FrameCols) : 1,
  parameter int WinAddrWidth   = ($clog2(WinRows * WinCols) > 0) ?
                                 $clog2(WinRows * WinCols) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  output logic [FrameAddrWidth-1:0] frame_addr_o,
  input  logic [PixW-1:0]           frame_data_i,
  output logic [WinAddrWidth-1:0]   win_addr_o,
  input  logic [PixW-1:0]           win_data_i,
  output logic [SadW-1:0]           sad_o,
  output logic [CoordW-1:0]         sad_row_o,
  output logic [CoordW-1:0]         sad_col_o,
  output logic                      sad_valid_o,
  output logic                      busy_o,
  output logic                      done_o
);

  if (WinRows < 1 || WinCols < 1 || WinRows > FrameRows || WinCols > FrameCols ||
      FrameRows > 256 || FrameCols > 256) begin : g_bad_geometry
    $error("sad_search_engine: need 1 <= Win <= Frame <= 256 in both dimensions");
  end

  state_e state_q, state_d;
  logic   step;
  coord_t row, col;
  logic   first_off, last_off, last_cand;

  // Tags for the address issued last cycle, aligned with the returning data.
  logic   p_valid_q, p_first_q, p_last_q, p_final_q;
  coord_t p_row_q, p_col_q;

  sad_t   acc_q, acc_d, sad_q;
  coord_t sad_row_q, sad_col_q;
  logic   sad_valid_q, final_q;
  pixel_t diff;

  assign step = (state_q == ST_SCAN);

  sad_addr_gen #(
    .FrameRows      (FrameRows),
    .FrameCols      (FrameCols),
    .WinRows        (WinRows),
    .WinCols        (WinCols),
    .FrameAddrWidth (FrameAddrWidth),
    .WinAddrWidth   (WinAddrWidth)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .step_i       (step),
    .frame_addr_o (frame_addr_o),
    .win_addr_o   (win_addr_o),
    .row_o        (row),
    .col_o        (col),
    .first_off_o  (first_off),
    .last_off_o   (last_off),
    .last_cand_o  (last_cand)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SCAN;
      ST_SCAN:  if (last_off && last_cand) state_d = ST_DRAIN;
      ST_DRAIN: if (final_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // First term of each candidate overwrites so back-to-back positions need no gap.
  assign diff  = abs_diff(frame_data_i, win_data_i);
  assign acc_d = (p_first_q ? '0 : acc_q) + sad_t'(diff);

  // NOTE: pipeline and accumulator registers are all reset, so an abort
  // leaves no in-flight tag able to fire a strobe after reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_final_q   <= 1'b0;
      p_row_q     <= '0;
      p_col_q     <= '0;
      acc_q       <= '0;
      sad_q       <= '0;
      sad_row_q   <= '0;
      sad_col_q   <= '0;
      sad_valid_q <= 1'b0;
      final_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_valid_q   <= step;
      p_first_q   <= first_off;
      p_last_q    <= last_off;
      p_final_q   <= last_off && last_cand;
      p_row_q     <= row;
      p_col_q     <= col;
      sad_valid_q <= p_valid_q && p_last_q;
      final_q     <= p_valid_q && p_last_q && p_final_q;
      if (p_valid_q) begin
        acc_q <= acc_d;
      end
      if (p_valid_q && p_last_q) begin
        sad_q     <= acc_d;
        sad_row_q <= p_row_q;
        sad_col_q <= p_col_q;
      end
    end
  end

  assign sad_o       = sad_q;
  assign sad_row_o   = sad_row_q;
  assign sad_col_o   = sad_col_q;
  assign sad_valid_o = sad_valid_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sad_search_engine.sv
// Directed bench: 4x4 frame with 2x2 and 4x4 templates, synchronous-read
// memory models, strobe/Done timing, restart, abort and reference SADs.
module tb_sad_search_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [3:0]  faddr_a, faddr_b, waddr_b;
  logic [1:0]  waddr_a;
  logic [7:0]  fdata_a, fdata_b, wdata_a, wdata_b;
  logic [31:0] sad_a, sad_b;
  logic [7:0]  row_a, col_a, row_b, col_b;
  logic        vld_a, vld_b, busy_a, busy_b, done_a, done_b;

  logic [7:0] frame_mem [16];
  logic [7:0] win_a_mem [4];
  logic [7:0] win_b_mem [16];

  always @(posedge clk) begin
    fdata_a <= frame_mem[faddr_a];
    wdata_a <= win_a_mem[waddr_a];
    fdata_b <= frame_mem[faddr_b];
    wdata_b <= win_b_mem[waddr_b];
  end

  sad_search_engine #(.FrameRows(4), .FrameCols(4), .WinRows(2), .WinCols(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a),
    .frame_addr_o(faddr_a), .frame_data_i(fdata_a),
    .win_addr_o(waddr_a), .win_data_i(wdata_a),
    .sad_o(sad_a), .sad_row_o(row_a), .sad_col_o(col_a),
    .sad_valid_o(vld_a), .busy_o(busy_a), .done_o(done_a)
  );

  sad_search_engine #(.FrameRows(4), .FrameCols(4), .WinRows(4), .WinCols(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b),
    .frame_addr_o(faddr_b), .frame_data_i(fdata_b),
    .win_addr_o(waddr_b), .win_data_i(wdata_b),
    .sad_o(sad_b), .sad_row_o(row_b), .sad_col_o(col_b),
    .sad_valid_o(vld_b), .busy_o(busy_b), .done_o(done_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int          v_cyc[$];
  logic [31:0] v_sad[$];
  logic [7:0]  v_row[$], v_col[$];
  int          done_cnt, done_cyc;
  logic        busy_log [64];
  int          fa_log [64], wa_log [64];
  logic [63:0] snap;
  int          exp_sad [9];

  // Start sampled at the end of cycle 0; outputs observed mid-cycle at negedge.
  task automatic run_scan(input bit use_b, input int restart_at, input int abort_at,
                          input int n_cyc);
    v_cyc.delete(); v_sad.delete(); v_row.delete(); v_col.delete();
    done_cnt = 0; done_cyc = -1; snap = '1;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      if (use_b ? vld_b : vld_a) begin
        v_cyc.push_back(c);
        v_sad.push_back(use_b ? sad_b : sad_a);
        v_row.push_back(use_b ? row_b : row_a);
        v_col.push_back(use_b ? col_b : col_a);
      end
      if (use_b ? done_b : done_a) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c < 64) begin
        busy_log[c] = use_b ? busy_b : busy_a;
        fa_log[c]   = int'(use_b ? faddr_b : faddr_a);
        wa_log[c]   = int'(use_b ? waddr_b : {2'b00, waddr_a});
      end
      if (abort_at > 0 && c == abort_at + 1)
        snap = {7'd0, sad_a, row_a, col_a, vld_a, busy_a, done_a, faddr_a, waddr_a};
      start_a = (!use_b && c == restart_at);
      start_b = 1'b0;
      rst_n   = !(abort_at > 0 && c >= abort_at && c < abort_at + 2);
    end
  endtask

  task automatic verify_a(input string tag);
    check({tag, "_nvalid"}, v_cyc.size(), 9);
    for (int k = 0; k < 9 && k < v_cyc.size(); k++) begin
      check($sformatf("%s_cyc%0d", tag, k), v_cyc[k], 6 + 4 * k);
      check($sformatf("%s_sad%0d", tag, k), v_sad[k], exp_sad[k]);
      check($sformatf("%s_row%0d", tag, k), v_row[k], k / 3);
      check($sformatf("%s_col%0d", tag, k), v_col[k], k % 3);
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc, 39);
  endtask

  function automatic int ref_sad(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        int d = int'(frame_mem[(r + i) * 4 + c + j]) - int'(win_a_mem[i * 2 + j]);
        s += (d < 0) ? -d : d;
      end
    return s;
  endfunction

  task automatic load_gradient();
    for (int p = 0; p < 16; p++) frame_mem[p] = 8'(p);
    win_a_mem[0] = 8'd6;  win_a_mem[1] = 8'd7;
    win_a_mem[2] = 8'd10; win_a_mem[3] = 8'd11;
    for (int k = 0; k < 9; k++) exp_sad[k] = ref_sad(k / 3, k % 3);
  endtask

  initial begin
    for (int p = 0; p < 16; p++) begin frame_mem[p] = 8'd0; win_b_mem[p] = 8'd0; end
    for (int p = 0; p < 4; p++) win_a_mem[p] = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_outs_a", {sad_a, row_a, col_a, vld_a, busy_a, done_a, faddr_a, waddr_a}, 0);
    check("rst_outs_b", {sad_b, row_b, col_b, vld_b, busy_b, done_b, faddr_b, waddr_b}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero memories: SAD 0 everywhere, timing and raster order.
    for (int k = 0; k < 9; k++) exp_sad[k] = 0;
    run_scan(1'b0, 0, 0, 45);
    verify_a("zero");
    check("busy_c1", busy_log[1], 1);
    check("busy_c39", busy_log[39], 1);
    check("busy_c40", busy_log[40], 0);
    check("faddr_c1", fa_log[1], 0);
    check("faddr_c2", fa_log[2], 1);
    check("faddr_c3", fa_log[3], 4);
    check("faddr_c5", fa_log[5], 1);
    check("faddr_c36", fa_log[36], 15);
    check("waddr_c3", wa_log[3], 2);
    check("waddr_c4", wa_log[4], 3);

    // Frame 255 against zero template: 4 * 255 per position.
    for (int p = 0; p < 16; p++) frame_mem[p] = 8'd255;
    for (int k = 0; k < 9; k++) exp_sad[k] = 1020;
    run_scan(1'b0, 0, 0, 45);
    verify_a("sat");

    // Gradient frame, template copied from (1,2).
    load_gradient();
    run_scan(1'b0, 0, 0, 45);
    verify_a("grad");
    if (v_sad.size() == 9) begin
      check("grad_match_1_2", v_sad[5], 0);
      check("grad_near_1_1", v_sad[4], 4);
      check("grad_far_0_2", v_sad[2], 16);
    end else check("grad_hand_count", v_sad.size(), 9);

    // Start re-asserted mid-scan must be ignored.
    run_scan(1'b0, 20, 0, 45);
    verify_a("restart");

    // Abort at cycle 15 for two cycles.
    run_scan(1'b0, 0, 15, 45);
    check("abort_outs_zero", snap, 0);
    check("abort_nvalid", v_cyc.size(), 3);
    if (v_cyc.size() > 0) check("abort_last_valid_cyc", v_cyc[v_cyc.size() - 1], 14);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_idle_busy", busy_log[30], 0);

    run_scan(1'b0, 0, 0, 45);
    verify_a("post_abort");

    // 4x4 template over 4x4 frame: one position, SAD = 0+1+...+15.
    run_scan(1'b1, 0, 0, 25);
    check("full_nvalid", v_cyc.size(), 1);
    if (v_cyc.size() > 0) begin
      check("full_cyc", v_cyc[0], 18);
      check("full_sad", v_sad[0], 120);
      check("full_row", v_row[0], 0);
      check("full_col", v_col[0], 0);
    end
    check("full_done_cyc", done_cyc, 19);
    check("full_busy_c20", busy_log[20], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
